// File: rtl/st7789_spi_rx.sv
// Receive side of a 4-wire ST7789 SPI link: oversamples sda/scl/cs/rs, assembles bytes,
// and decodes the window/RAMWR command subset into RGB565 pixel writes with positions.
module st7789_spi_rx #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sda,
    input  logic                      scl,
    input  logic                      cs,
    input  logic                      rs,
    output logic                      byte_valid,
    output logic [7:0]                byte_data,
    output logic                      byte_rs,
    output logic                      pix_we,
    output logic [15:0]               pix_data,
    output logic [$clog2(WIDTH)-1:0]  hpos,
    output logic [$clog2(HEIGHT)-1:0] vpos,
    output logic                      sleep_out,
    output logic                      display_on,
    output logic                      ramwr_active
);
    localparam int HW = $clog2(WIDTH);
    localparam int VW = $clog2(HEIGHT);
    localparam int PW = (HW > VW) ? HW : VW;
    localparam logic [15:0]   XMAX   = 16'(WIDTH - 1);
    localparam logic [15:0]   YMAX   = 16'(HEIGHT - 1);
    localparam logic [HW-1:0] XE_RST = HW'(WIDTH - 1);
    localparam logic [VW-1:0] YE_RST = VW'(HEIGHT - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_RAMWR = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sda_sync_r, scl_sync_r, cs_sync_r, rs_sync_r;
    logic scl_prev_r, cs_prev_r;
    logic sda_s, scl_s, cs_s, rs_s, scl_rise_s, cs_rise_s;
    logic [6:0] shift_r;
    logic [2:0] bit_cnt_r;

    state_t state_r, state_next;
    logic [7:0]  opcode_r, opcode_next, hi_r, hi_next, end_hi_r, end_hi_next;
    logic [2:0]  pidx_r, pidx_next;
    logic        phase_r, phase_next;
    logic [15:0] start_r, start_next;
    logic [HW-1:0] xs_r, xs_next, xe_r, xe_next, hpos_next;
    logic [VW-1:0] ys_r, ys_next, ye_r, ye_next, vpos_next;
    logic        pix_we_next, sleep_next, disp_next;
    logic [15:0] pix_data_next;
    logic [15:0] lim_s, pend_s;
    logic [PW-1:0] st_s, en_raw_s, en_s;

    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign rs_s       = rs_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r & ~cs_s;
    assign cs_rise_s  = cs_s & ~cs_prev_r;

    // Window parameters clamp to the panel edge, and an inverted range collapses to start.
    assign lim_s    = (opcode_r == 8'h2B) ? YMAX : XMAX;
    assign pend_s   = {end_hi_r, byte_data};
    assign st_s     = (start_r > lim_s) ? lim_s[PW-1:0] : start_r[PW-1:0];
    assign en_raw_s = (pend_s > lim_s) ? lim_s[PW-1:0] : pend_s[PW-1:0];
    assign en_s     = (st_s > en_raw_s) ? st_s : en_raw_s;

    // Input synchronisers and previous-value taps for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_sync_r <= {SYNC_STAGES{1'b0}};
            scl_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r  <= {SYNC_STAGES{1'b1}};
            rs_sync_r  <= {SYNC_STAGES{1'b0}};
            scl_prev_r <= 1'b0;
            cs_prev_r  <= 1'b1;
        end else begin
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs};
            rs_sync_r  <= {rs_sync_r[SYNC_STAGES-2:0], rs};
            scl_prev_r <= scl_s;
            cs_prev_r  <= cs_s;
        end
    end

    // Byte assembly: MSB first, strobe on the eighth qualified scl rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r    <= 7'd0;
            bit_cnt_r  <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_rs    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_rise_s) begin
                bit_cnt_r <= 3'd0;
            end else if (scl_rise_s) begin
                shift_r   <= {shift_r[5:0], sda_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift_r, sda_s};
                    byte_rs    <= rs_s;
                end
            end
        end
    end

    // Parser next-state: pixel advance, command/parameter/pixel decode, then cs cleanup.
    always_comb begin
        state_next    = state_r;
        opcode_next   = opcode_r;
        pidx_next     = pidx_r;
        phase_next    = phase_r;
        hi_next       = hi_r;
        start_next    = start_r;
        end_hi_next   = end_hi_r;
        xs_next       = xs_r;
        xe_next       = xe_r;
        ys_next       = ys_r;
        ye_next       = ye_r;
        pix_we_next   = 1'b0;
        pix_data_next = pix_data;
        hpos_next     = hpos;
        vpos_next     = vpos;
        sleep_next    = sleep_out;
        disp_next     = display_on;

        if (pix_we) begin
            if (hpos == xe_r) begin
                hpos_next = xs_r;
                vpos_next = (vpos == ye_r) ? ys_r : vpos + V_ONE;
            end else begin
                hpos_next = hpos + H_ONE;
            end
        end else begin
            hpos_next = hpos;
        end

        if (byte_valid && !byte_rs) begin
            opcode_next = byte_data;
            pidx_next   = 3'd0;
            phase_next  = 1'b0;
            state_next  = ST_IDLE;
            case (byte_data)
                8'h01: begin
                    sleep_next = 1'b0;
                    disp_next  = 1'b0;
                    xs_next    = {HW{1'b0}};
                    xe_next    = XE_RST;
                    ys_next    = {VW{1'b0}};
                    ye_next    = YE_RST;
                end
                8'h10: sleep_next = 1'b0;
                8'h11: sleep_next = 1'b1;
                8'h28: disp_next  = 1'b0;
                8'h29: disp_next  = 1'b1;
                8'h2A, 8'h2B: state_next = ST_PARAM;
                8'h2C: begin
                    hpos_next  = xs_r;
                    vpos_next  = ys_r;
                    state_next = ST_RAMWR;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (byte_valid) begin
            case (state_r)
                ST_PARAM: begin
                    case (pidx_r)
                        3'd0: start_next[15:8] = byte_data;
                        3'd1: start_next[7:0]  = byte_data;
                        3'd2: end_hi_next      = byte_data;
                        3'd3: begin
                            if (opcode_r == 8'h2A) begin
                                xs_next = st_s[HW-1:0];
                                xe_next = en_s[HW-1:0];
                            end else begin
                                ys_next = st_s[VW-1:0];
                                ye_next = en_s[VW-1:0];
                            end
                        end
                        default: end_hi_next = end_hi_r;
                    endcase
                    pidx_next = (pidx_r == 3'd4) ? 3'd4 : pidx_r + 3'd1;
                end
                ST_RAMWR: begin
                    if (!phase_r) begin
                        hi_next    = byte_data;
                        phase_next = 1'b1;
                    end else begin
                        pix_we_next   = 1'b1;
                        pix_data_next = {hi_r, byte_data};
                        phase_next    = 1'b0;
                    end
                end
                default: state_next = state_r;
            endcase
        end else begin
            state_next = state_r;
        end

        if (cs_rise_s) begin
            phase_next = 1'b0;
            state_next = (state_next == ST_RAMWR) ? ST_IDLE : state_next;
        end else begin
            phase_next = phase_next;
        end
    end

    // Parser state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            opcode_r     <= 8'd0;
            pidx_r       <= 3'd0;
            phase_r      <= 1'b0;
            hi_r         <= 8'd0;
            start_r      <= 16'd0;
            end_hi_r     <= 8'd0;
            xs_r         <= {HW{1'b0}};
            xe_r         <= XE_RST;
            ys_r         <= {VW{1'b0}};
            ye_r         <= YE_RST;
            pix_we       <= 1'b0;
            pix_data     <= 16'd0;
            hpos         <= {HW{1'b0}};
            vpos         <= {VW{1'b0}};
            sleep_out    <= 1'b0;
            display_on   <= 1'b0;
            ramwr_active <= 1'b0;
        end else begin
            state_r      <= state_next;
            opcode_r     <= opcode_next;
            pidx_r       <= pidx_next;
            phase_r      <= phase_next;
            hi_r         <= hi_next;
            start_r      <= start_next;
            end_hi_r     <= end_hi_next;
            xs_r         <= xs_next;
            xe_r         <= xe_next;
            ys_r         <= ys_next;
            ye_r         <= ye_next;
            pix_we       <= pix_we_next;
            pix_data     <= pix_data_next;
            hpos         <= hpos_next;
            vpos         <= vpos_next;
            sleep_out    <= sleep_next;
            display_on   <= disp_next;
            ramwr_active <= (state_next == ST_RAMWR);
        end
    end
endmodule

// File: tb/tb_st7789_spi_rx.sv
// Scoreboard bench for st7789_spi_rx: a 320x240 instance for protocol checks and a 4x3
// instance (fed only during the last phase) for the full-frame wrap.
module tb_st7789_spi_rx;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset, sda, scl, cs, rs, small_en, cs_small;

    logic        byte_valid, byte_rs, pix_we, sleep_out, display_on, ramwr_active;
    logic [7:0]  byte_data;
    logic [15:0] pix_data;
    logic [8:0]  hpos;
    logic [7:0]  vpos;

    logic        s_byte_valid, s_byte_rs, s_pix_we, s_sleep_out, s_display_on, s_ramwr_active;
    logic [7:0]  s_byte_data;
    logic [15:0] s_pix_data;
    logic [1:0]  s_hpos, s_vpos;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_edge_cyc = 0;

    logic [8:0]  exp_byte_q[$];
    logic [32:0] exp_pix_q[$];
    logic [19:0] exp_small_q[$];

    st7789_spi_rx #(.WIDTH(320), .HEIGHT(240), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs), .rs(rs),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
        .pix_we(pix_we), .pix_data(pix_data), .hpos(hpos), .vpos(vpos),
        .sleep_out(sleep_out), .display_on(display_on), .ramwr_active(ramwr_active)
    );

    st7789_spi_rx #(.WIDTH(4), .HEIGHT(3), .SYNC_STAGES(SS)) u_small (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs_small), .rs(rs),
        .byte_valid(s_byte_valid), .byte_data(s_byte_data), .byte_rs(s_byte_rs),
        .pix_we(s_pix_we), .pix_data(s_pix_data), .hpos(s_hpos), .vpos(s_vpos),
        .sleep_out(s_sleep_out), .display_on(s_display_on), .ramwr_active(s_ramwr_active)
    );

    assign cs_small = small_en ? cs : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 'h%0h, expected no strobe", name, act);
    endtask

    // Monitor: pops expectations whenever a DUT presents a byte or a pixel.
    always @(negedge clk) begin
        if (byte_valid) begin
            if (exp_byte_q.size() == 0) begin
                unexpected("byte strobe", {byte_rs, byte_data});
            end else begin
                check("byte", {byte_rs, byte_data}, exp_byte_q.pop_front());
                check("byte latency", cyc - last_edge_cyc, SS + 1);
            end
        end
        if (pix_we) begin
            if (exp_pix_q.size() == 0) unexpected("pix_we", {hpos, vpos, pix_data});
            else check("pixel", {hpos, vpos, pix_data}, exp_pix_q.pop_front());
        end
        if (s_pix_we) begin
            if (exp_small_q.size() == 0) unexpected("small pix_we", {s_hpos, s_vpos, s_pix_data});
            else check("small pixel", {s_hpos, s_vpos, s_pix_data}, exp_small_q.pop_front());
        end
    end

    task automatic send_bits(input logic r, input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk); sda = d[i]; rs = r;
            @(negedge clk); scl = 1'b1;
            if (i == 0) last_edge_cyc = cyc;
            @(negedge clk);
            @(negedge clk); scl = 1'b0;
        end
    endtask

    task automatic send_byte(input logic r, input logic [7:0] d);
        exp_byte_q.push_back({r, d});
        send_bits(r, d, 8);
    endtask

    task automatic cmd4(input logic [7:0] op, input logic [31:0] p);
        send_byte(1'b0, op);
        for (int i = 3; i >= 0; i--) send_byte(1'b1, p[i*8 +: 8]);
    endtask

    task automatic pixel(input int x, input int y, input logic [15:0] v);
        exp_pix_q.push_back({9'(x), 8'(y), v});
        send_byte(1'b1, v[15:8]);
        send_byte(1'b1, v[7:0]);
    endtask

    task automatic cs_low();
        @(negedge clk); cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    int px3[7]  = '{0, 1, 2, 0, 1, 2, 0};
    int py3[7]  = '{1, 1, 1, 2, 2, 2, 1};
    int sx[13]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int sy[13]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};

    initial begin
        reset = 1'b1; sda = 1'b0; scl = 1'b0; cs = 1'b1; rs = 1'b0; small_en = 1'b0;
        repeat (4) @(negedge clk);
        check("reset outputs", {byte_valid, byte_data, byte_rs, pix_we, pix_data, hpos, vpos,
                                sleep_out, display_on, ramwr_active}, 64'd0);
        reset = 1'b0;
        cs_low();

        // Sleep-out command and first RAMWR pair
        send_byte(1'b0, 8'h11); settle();
        check("sleep_out after 0x11", sleep_out, 64'd1);
        send_byte(1'b0, 8'h2C); settle();
        check("ramwr_active after 0x2C", ramwr_active, 64'd1);
        pixel(0, 0, 16'hF800);
        pixel(1, 0, 16'h07E0);

        // 3x2 window with wrap back to (0,1)
        cmd4(8'h2A, 32'h0000_0002);
        cmd4(8'h2B, 32'h0001_0002);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 7; i++) pixel(px3[i], py3[i], 16'h1000 + 16'(i));

        // Clamp of end column to 319, then inverted range collapsing to column 5
        cmd4(8'h2B, 32'h0000_0001);
        cmd4(8'h2A, 32'h013E_0200);
        send_byte(1'b0, 8'h2C);
        pixel(318, 0, 16'h2001);
        pixel(319, 0, 16'h2002);
        pixel(318, 1, 16'h2003);
        cmd4(8'h2A, 32'h0005_0003);
        send_byte(1'b0, 8'h2C);
        pixel(5, 0, 16'h3001);
        pixel(5, 1, 16'h3002);
        pixel(5, 0, 16'h3003);

        // Partial byte discarded by cs rise; position and bit counter behaviour
        send_bits(1'b1, 8'hAA, 5);
        cs_high();
        check("ramwr_active after cs rise", ramwr_active, 64'd0);
        check("hpos kept over cs rise", hpos, 64'd5);
        check("vpos kept over cs rise", vpos, 64'd1);
        cs_low();
        send_byte(1'b0, 8'h29); settle();
        check("display_on after 0x29", display_on, 64'd1);
        send_byte(1'b0, 8'h2C);
        pixel(5, 0, 16'hABCD);
        send_byte(1'b1, 8'h12);
        cs_high();
        check("ramwr_active after half pixel", ramwr_active, 64'd0);
        check("hpos after half pixel", hpos, 64'd5);
        check("vpos after half pixel", vpos, 64'd1);
        cs_low();
        send_byte(1'b1, 8'h34);
        send_byte(1'b1, 8'h56);
        send_byte(1'b0, 8'h2C);
        pixel(5, 0, 16'h3456);

        // SWRESET, then a frame through the 4x3 instance (12 pixels + wrap)
        send_byte(1'b0, 8'h01); settle();
        check("sleep_out after 0x01", sleep_out, 64'd0);
        check("display_on after 0x01", display_on, 64'd0);
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h29);
        cs_high();
        small_en = 1'b1;
        cs_low();
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 13; i++) begin
            exp_small_q.push_back({2'(sx[i]), 2'(sy[i]), 16'h4000 + 16'(i)});
            pixel(i, 0, 16'h4000 + 16'(i));
        end
        settle();
        check("small last-wrap hpos", s_hpos, 64'd1);
        check("small last-wrap vpos", s_vpos, 64'd0);

        // Reset in the middle of a pixel
        send_byte(1'b1, 8'h77);
        settle();
        reset = 1'b1;
        @(negedge clk);
        check("mid-stream reset outputs", {byte_valid, byte_data, byte_rs, pix_we, pix_data, hpos,
                                           vpos, sleep_out, display_on, ramwr_active}, 64'd0);
        check("small reset outputs", {s_byte_valid, s_byte_data, s_byte_rs, s_pix_we, s_pix_data,
                                      s_hpos, s_vpos, s_sleep_out, s_display_on, s_ramwr_active}, 64'd0);
        reset = 1'b0;
        cs_high();
        settle();

        check("byte queue drained", exp_byte_q.size(), 64'd0);
        check("pixel queue drained", exp_pix_q.size(), 64'd0);
        check("small queue drained", exp_small_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
